ef_gpio_filtered: RTL and testbench

Parametrised N-pin GPIO front end sitting between the pads and the bus/register wrapper. Adds to the plain 8-pin synchroniser and edge-detector block:
- configurable synchroniser depth;
- a per-pin programmable debounce filter;
- per-pin interrupt type selection;
- sticky write-1-to-clear interrupt status with a single aggregated IRQ line.

Output drive paths (`io_out`, `io_oe`) remain pass-through.

---
 rtl/ef_gpio_pkg.sv | 22 ++
 rtl/ef_gpio_debounce.sv | 51 +++++
 rtl/ef_gpio_filtered.sv | 69 ++++++
 tb/tb_ef_gpio_filtered.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ef_gpio_pkg.sv
// Shared definitions for the filtered GPIO block: interrupt type encodings
// and the per-pin interrupt condition decoder.
package ef_gpio_pkg;

    localparam logic [1:0] IRQ_HIGH = 2'b00;
    localparam logic [1:0] IRQ_LOW  = 2'b01;
    localparam logic [1:0] IRQ_RISE = 2'b10;
    localparam logic [1:0] IRQ_FALL = 2'b11;

    // True when a pin with filtered value f (previous value fd) meets its type.
    function automatic logic irq_hit(input logic [1:0] kind, input logic f, input logic fd);
        logic hit;
        case (kind)
            IRQ_HIGH: hit = f;
            IRQ_LOW:  hit = ~f;
            IRQ_RISE: hit = f & ~fd;
            default:  hit = ~f & fd;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/ef_gpio_debounce.sv
// One pin: synchroniser chain, debounce filter and the delayed filtered copy
// used for edge detection.
module ef_gpio_debounce
    import ef_gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pin_in,
    input  logic            db_en,
    input  logic [DB_W-1:0] db_limit,
    output logic            f,
    output logic            fd
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [DB_W-1:0]        cnt;
    logic                   s;
    logic [DB_W-1:0]        limit_m1;

    assign s        = sync_q[SYNC_STAGES-1];
    assign limit_m1 = db_limit - DB_W'(1);

    // NOTE: every register here uses <= so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            f      <= 1'b0;
            fd     <= 1'b0;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_in};
            fd     <= f;
            if (!db_en || db_limit == '0) begin
                f   <= s;
                cnt <= '0;
            end else if (s == f) begin
                cnt <= '0;
            end else if (cnt >= limit_m1) begin
                // >= so a limit lowered mid-count commits on the next cycle.
                f   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end
    end

endmodule

// File: rtl/ef_gpio_filtered.sv
// N-pin GPIO front end: per-pin debounced inputs, typed interrupts with
// sticky write-1-to-clear status and one aggregated IRQ; outputs pass through.
module ef_gpio_filtered
    import ef_gpio_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DB_W        = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    io_in,
    output logic [N-1:0]    io_out,
    output logic [N-1:0]    io_oe,
    input  logic [N-1:0]    bus_out,
    input  logic [N-1:0]    bus_oe,
    output logic [N-1:0]    bus_in,
    input  logic [N-1:0]    db_en,
    input  logic [DB_W-1:0] db_limit,
    input  logic [2*N-1:0]  irq_type,
    input  logic [N-1:0]    irq_en,
    input  logic [N-1:0]    irq_clr,
    output logic [N-1:0]    irq_status,
    output logic            irq
);

    logic [N-1:0] pin_f;
    logic [N-1:0] pin_fd;
    logic [N-1:0] hit;

    assign io_out = bus_out;
    assign io_oe  = bus_oe;
    assign bus_in = pin_f;

    for (genvar i = 0; i < N; i++) begin : g_pin
        ef_gpio_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_W        (DB_W)
        ) u_db (
            .clk      (clk),
            .rst_n    (rst_n),
            .pin_in   (io_in[i]),
            .db_en    (db_en[i]),
            .db_limit (db_limit),
            .f        (pin_f[i]),
            .fd       (pin_fd[i])
        );
    end

    // NOTE: default assignment first so no path through the loop infers a latch.
    always_comb begin
        hit = '0;
        for (int i = 0; i < N; i++) begin
            hit[i] = irq_hit(irq_type[2*i +: 2], pin_f[i], pin_fd[i]);
        end
    end

    // Set term is OR-ed after the clear so a simultaneous set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_status <= '0;
        end else begin
            irq_status <= (irq_status & ~irq_clr) | (hit & irq_en);
        end
    end

    assign irq = |irq_status;

endmodule

// File: tb/tb_ef_gpio_filtered.sv
// Directed bench for ef_gpio_filtered with a run-length behavioural model
// checked every cycle, plus hand-computed literal expectations.
module tb_ef_gpio_filtered;
    import ef_gpio_pkg::*;

    localparam int N    = 8;
    localparam int SYNC = 2;
    localparam int DB_W = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    io_in, io_out, io_oe, bus_out, bus_oe, bus_in;
    logic [N-1:0]    db_en, irq_en, irq_clr, irq_status;
    logic [DB_W-1:0] db_limit;
    logic [2*N-1:0]  irq_type;
    logic            irq;

    int compared   = 0;
    int mismatched = 0;

    ef_gpio_filtered #(.N(N), .SYNC_STAGES(SYNC), .DB_W(DB_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .io_in      (io_in),
        .io_out     (io_out),
        .io_oe      (io_oe),
        .bus_out    (bus_out),
        .bus_oe     (bus_oe),
        .bus_in     (bus_in),
        .db_en      (db_en),
        .db_limit   (db_limit),
        .irq_type   (irq_type),
        .irq_en     (irq_en),
        .irq_clr    (irq_clr),
        .irq_status (irq_status),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Model: the pin value seen by the filter is io_in delayed SYNC cycles; the
    // filtered value follows it once it has disagreed for db_limit straight cycles.
    logic [N-1:0] m_pipe [SYNC];
    logic [N-1:0] m_f = '0, m_fd = '0, m_status = '0, m_nf, m_hit, m_s;
    int           m_run [N];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < SYNC; k++) m_pipe[k] = '0;
            for (int i = 0; i < N; i++) m_run[i] = 0;
            m_f = '0;
            m_fd = '0;
            m_status = '0;
        end else begin
            m_s = m_pipe[SYNC-1];
            for (int i = 0; i < N; i++) begin
                m_nf[i] = m_f[i];
                if (!db_en[i] || db_limit == 0) begin
                    m_nf[i] = m_s[i];
                    m_run[i] = 0;
                end else if (m_s[i] == m_f[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i] = m_run[i] + 1;
                    if (m_run[i] >= int'(db_limit)) begin
                        m_nf[i] = m_s[i];
                        m_run[i] = 0;
                    end
                end
                case (irq_type[2*i +: 2])
                    2'b00:   m_hit[i] = m_f[i];
                    2'b01:   m_hit[i] = !m_f[i];
                    2'b10:   m_hit[i] = m_f[i] && !m_fd[i];
                    default: m_hit[i] = !m_f[i] && m_fd[i];
                endcase
            end
            m_status = (m_status & ~irq_clr) | (m_hit & irq_en);
            m_fd = m_f;
            m_f = m_nf;
            for (int k = SYNC - 1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
            m_pipe[0] = io_in;
        end
    end

    always @(negedge clk) begin
        check("bus_in",     32'(bus_in),     32'(m_f));
        check("irq_status", 32'(irq_status), 32'(m_status));
        check("irq",        32'(irq),        32'(|m_status));
        check("io_out",     32'(io_out),     32'(bus_out));
        check("io_oe",      32'(io_oe),      32'(bus_oe));
    end

    initial begin
        rst_n = 1'b0;
        io_in = '0;
        bus_out = 8'hA5;
        bus_oe = 8'h3C;
        db_en = '0;
        db_limit = 8'd5;
        irq_type = '0;
        irq_en = '0;
        irq_clr = '0;

        #12;
        check("rst_bus_in", 32'(bus_in), 32'h0);
        check("rst_status", 32'(irq_status), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_io_out", 32'(io_out), 32'hA5);
        check("rst_io_oe", 32'(io_oe), 32'h3C);
        bus_out = 8'h5A;
        #1;
        check("rst_io_out_comb", 32'(io_out), 32'h5A);
        #7 rst_n = 1'b1;
        tick(2);

        // Rising edge, no debounce
        irq_type[1:0] = IRQ_RISE;
        irq_en[0] = 1'b1;
        tick(1);
        io_in[0] = 1'b1;
        tick(2);
        check("p0_bus_in_early", 32'(bus_in[0]), 32'h0);
        tick(1);
        check("p0_bus_in", 32'(bus_in[0]), 32'h1);
        check("p0_status_early", 32'(irq_status[0]), 32'h0);
        tick(1);
        check("p0_status", 32'(irq_status[0]), 32'h1);
        check("p0_irq", 32'(irq), 32'h1);
        irq_clr[0] = 1'b1;
        tick(1);
        irq_clr = '0;
        check("p0_cleared", 32'(irq_status[0]), 32'h0);
        check("p0_irq_cleared", 32'(irq), 32'h0);

        // Debounce: short bounce rejected, then a 5-cycle hold accepted
        db_en[1] = 1'b1;
        io_in[1] = 1'b1;
        tick(3);
        io_in[1] = 1'b0;
        tick(8);
        check("p1_bounce", 32'(bus_in[1]), 32'h0);
        io_in[1] = 1'b1;
        tick(6);
        check("p1_before", 32'(bus_in[1]), 32'h0);
        tick(1);
        check("p1_accept", 32'(bus_in[1]), 32'h1);

        // Level high: clear is ineffective while level persists
        irq_type[5:4] = IRQ_HIGH;
        irq_en[2] = 1'b1;
        io_in[2] = 1'b1;
        tick(4);
        check("p2_set", 32'(irq_status[2]), 32'h1);
        irq_clr[2] = 1'b1;
        tick(1);
        irq_clr = '0;
        check("p2_clr_held", 32'(irq_status[2]), 32'h1);
        io_in[2] = 1'b0;
        tick(4);
        check("p2_sticky", 32'(irq_status[2]), 32'h1);
        irq_clr[2] = 1'b1;
        tick(1);
        irq_clr = '0;
        check("p2_clr", 32'(irq_status[2]), 32'h0);

        // Falling edge gated by enable; disabling keeps status
        irq_type[7:6] = IRQ_FALL;
        io_in[3] = 1'b1;
        tick(5);
        io_in[3] = 1'b0;
        tick(5);
        check("p3_disabled", 32'(irq_status[3]), 32'h0);
        irq_en[3] = 1'b1;
        io_in[3] = 1'b1;
        tick(5);
        check("p3_rise_ignored", 32'(irq_status[3]), 32'h0);
        io_in[3] = 1'b0;
        tick(5);
        check("p3_fall", 32'(irq_status[3]), 32'h1);
        irq_en[3] = 1'b0;
        tick(2);
        check("p3_en_off", 32'(irq_status[3]), 32'h1);
        irq_clr[3] = 1'b1;
        tick(1);
        irq_clr = '0;

        // Rising edge coincident with clear: set wins
        irq_type[9:8] = IRQ_RISE;
        irq_en[4] = 1'b1;
        io_in[4] = 1'b1;
        tick(3);
        irq_clr[4] = 1'b1;
        tick(1);
        irq_clr = '0;
        check("p4_set_wins", 32'(irq_status[4]), 32'h1);

        // Filtered value toggling every cycle
        irq_type[11:10] = IRQ_RISE;
        irq_en[5] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            io_in[5] = ~io_in[5];
            tick(1);
        end
        tick(4);
        check("p5_toggle", 32'(irq_status[5]), 32'h1);
        irq_clr[5] = 1'b1;
        tick(1);
        irq_clr = '0;

        // Limit lowered below the running count commits next cycle
        db_en[7] = 1'b1;
        io_in[7] = 1'b1;
        tick(5);
        check("p7_counting", 32'(bus_in[7]), 32'h0);
        db_limit = 8'd2;
        tick(1);
        check("p7_new_limit", 32'(bus_in[7]), 32'h1);
        db_limit = 8'd5;

        // Asynchronous reset mid-count with status set
        db_en[6] = 1'b1;
        io_in[6] = 1'b1;
        tick(4);
        check("pre_rst_bus_in", 32'(bus_in), 32'h93);
        check("pre_rst_irq", 32'(irq), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_bus_in", 32'(bus_in), 32'h0);
        check("async_status", 32'(irq_status), 32'h0);
        check("async_irq", 32'(irq), 32'h0);
        io_in = '0;
        tick(1);
        #3 rst_n = 1'b1;
        tick(10);
        check("post_rst_status", 32'(irq_status), 32'h0);
        check("post_rst_bus_in", 32'(bus_in), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
